// File: rtl/fib_bcd_display_pkg.sv
// fib_bcd_display_pkg: FSM encodings, active-low 7-segment codes and one double-dabble step
package fib_bcd_display_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic [35:0] dd_step(input logic [35:0] v);
    logic [35:0] a;
    a = v;
    for (int i = 0; i < 5; i++)
      a[16+4*i +: 4] = (a[16+4*i +: 4] >= 4'd5) ? a[16+4*i +: 4] + 4'd3 : a[16+4*i +: 4];
    return {a[34:0], 1'b0};
  endfunction
endpackage

// File: rtl/fib_bcd_display_seg7_decode.sv
// seg7_decode: BCD digit plus blank flag to active-low {g,f,e,d,c,b,a} cathodes
module seg7_decode
  import fib_bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank)
      case (digit)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/fib_bcd_display.sv
// fib_bcd_display: captures in_val on in_valid, converts to 5-digit BCD (bcd/bcd_valid/over/busy) and scans 4 digits onto an/seg
module fib_bcd_display
  import fib_bcd_display_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_val,
  input  logic             in_valid,
  output logic             busy,
  output logic [19:0]      bcd,
  output logic             bcd_valid,
  output logic             over,
  output logic [3:0]       an,
  output logic [6:0]       seg
);
  localparam int DW = $clog2(SCAN_DIV);
  state_t           state;
  logic [WIDTH-1:0] sreg, pend_val, load_val;
  logic [19:0]      scr;
  logic [3:0]       cnt;
  logic             pend_v, load;
  logic [35:0]      nxt;
  logic [DW-1:0]    div;
  logic [1:0]       idx, nidx;
  logic [3:0]       dig;
  logic             blank;
  logic [6:0]       seg_d;
  assign nxt      = dd_step({scr, sreg});
  assign load     = in_valid && state == IDLE || state == DONE && (pend_v || in_valid);
  assign load_val = (state == DONE && pend_v) ? pend_val : in_val;
  assign busy     = state != IDLE || pend_v;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      scr       <= '0;
      cnt       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
      over      <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (load) begin
        state <= SHIFT;
        sreg  <= load_val;
        scr   <= '0;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        {scr, sreg} <= nxt;
        cnt         <= cnt + 4'd1;
        if (cnt == 4'd15) begin
          state     <= DONE;
          bcd       <= nxt[35:16];
          over      <= |nxt[35:32];
          bcd_valid <= 1'b1;
        end
      end else state <= IDLE;
    end
  end
  // in DONE a held request is consumed while a same-cycle strobe takes its place
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v   <= 1'b0;
      pend_val <= '0;
    end else if (in_valid && (state == SHIFT || state == DONE && pend_v)) begin
      pend_v   <= 1'b1;
      pend_val <= in_val;
    end else if (state == DONE) pend_v <= 1'b0;
  end
  assign nidx  = idx + 2'd1;
  assign dig   = bcd[{nidx, 2'b00} +: 4];
  assign blank = !over && nidx != 2'd0 && (bcd[15:0] >> {nidx, 2'b00}) == 16'd0;
  seg7_decode u_dec (.digit(dig), .blank(blank), .seg(seg_d));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      idx <= '0;
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= nidx;
      an  <= ~(4'b0001 << nidx);
      seg <= seg_d;
    end else div <= div + 1'b1;
  end
endmodule

// File: tb/tb_fib_bcd_display.sv
// tb_fib_bcd_display: randomized and directed checks of conversion, pending buffer, scan and reset
module tb_fib_bcd_display;
  localparam int SD = 4;
  localparam logic [6:0] TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic clk = 0, rst = 0, in_valid = 0, busy, bcd_valid, over;
  logic [15:0] in_val = 0;
  logic [19:0] bcd;
  logic [3:0] an;
  logic [6:0] seg;
  int pass = 0, total = 0, cyc = 0;
  logic [19:0] vq[$];
  int cq[$];
  fib_bcd_display #(.WIDTH(16), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_valid(in_valid), .busy(busy),
    .bcd(bcd), .bcd_valid(bcd_valid), .over(over), .an(an), .seg(seg));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bcd_valid) begin vq.push_back(bcd); cq.push_back(cyc); end
  function automatic int pw10(input int i);
    int p = 1;
    repeat (i) p *= 10;
    return p;
  endfunction
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pw10(i)) % 10);
    return r;
  endfunction
  function automatic logic [6:0] exp_seg(input int v, input int i);
    if (i > 0 && v / pw10(i) == 0) return 7'b1111111;
    return TBL[(v / pw10(i)) % 10];
  endfunction
  task automatic strobe(input int v);
    in_val = 16'(v);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic observe_scan(input int n, output logic [3:0][6:0] segs, output logic [3:0] seen, output int bad);
    logic [3:0] prev;
    prev = an; segs = '1; seen = '0; bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (an != 4'hf) begin
        if ($countones(~an) != 1) bad++;
        else for (int i = 0; i < 4; i++) if (!an[i]) begin segs[i] = seg; seen[i] = 1'b1; end
        if (prev != 4'hf && an != prev && an != {prev[2:0], prev[3]}) bad++;
      end
      prev = an;
    end
  endtask
  task automatic test_reset;
    logic [3:0][6:0] s; logic [3:0] seen; int bad;
    rst = 0;
    repeat (3) @(negedge clk);
    total++; if ({bcd, bcd_valid, over, busy, an, seg} !== {20'h0, 3'b000, 4'hf, 7'h7f})
      $display("FAIL reset_outputs got bcd=%h v=%b o=%b b=%b an=%b seg=%b", bcd, bcd_valid, over, busy, an, seg); else pass++;
    rst = 1;
    observe_scan(20, s, seen, bad);
    total++; if ({bcd, over, busy} !== 22'h0) $display("FAIL idle_state got bcd=%h o=%b b=%b want 0", bcd, over, busy); else pass++;
    total++; if (seen !== 4'hf || bad != 0) $display("FAIL idle_scan seen=%b bad=%0d want 1111/0", seen, bad); else pass++;
    total++; if (s !== {7'h7f, 7'h7f, 7'h7f, TBL[0]}) $display("FAIL idle_segs got %h want %h", s, {7'h7f, 7'h7f, 7'h7f, TBL[0]}); else pass++;
  endtask
  task automatic test_single;
    strobe(1234);
    total++; if (busy !== 1) $display("FAIL single_busy got %b want 1", busy); else pass++;
    repeat (15) @(negedge clk);
    total++; if (bcd_valid !== 0) $display("FAIL single_early got %b want 0", bcd_valid); else pass++;
    @(negedge clk);
    total++; if ({bcd_valid, bcd, over} !== {1'b1, to_bcd(1234), 1'b0})
      $display("FAIL single_result got v=%b bcd=%h o=%b want 1/%h/0", bcd_valid, bcd, over, to_bcd(1234)); else pass++;
    @(negedge clk);
    total++; if ({bcd_valid, busy} !== 2'b00) $display("FAIL single_after got v=%b b=%b want 0/0", bcd_valid, busy); else pass++;
  endtask
  task automatic test_max;
    logic [3:0][6:0] s; logic [3:0][6:0] e; logic [3:0] seen; int bad, k;
    strobe(65535);
    k = 0;
    while (!bcd_valid && k < 40) begin @(negedge clk); k++; end
    total++; if ({bcd, over} !== {to_bcd(65535), 1'b1}) $display("FAIL max_result got %h/%b want %h/1", bcd, over, to_bcd(65535)); else pass++;
    repeat (8) @(negedge clk);
    observe_scan(24, s, seen, bad);
    for (int i = 0; i < 4; i++) e[i] = exp_seg(65535, i);
    total++; if (seen !== 4'hf || bad != 0) $display("FAIL max_scan seen=%b bad=%0d want 1111/0", seen, bad); else pass++;
    total++; if (s !== e) $display("FAIL max_segs got %h want %h", s, e); else pass++;
  endtask
  task automatic test_back_to_back;
    vq.delete(); cq.delete();
    strobe(13);
    repeat (2) @(negedge clk);
    strobe(21);
    repeat (4) @(negedge clk);
    strobe(34);
    repeat (50) @(negedge clk);
    total++; if (vq.size() != 2) $display("FAIL b2b_count got %0d want 2", vq.size()); else pass++;
    if (vq.size() == 2) begin
      total++; if (vq[0] !== to_bcd(13) || vq[1] !== to_bcd(34))
        $display("FAIL b2b_values got %h,%h want %h,%h", vq[0], vq[1], to_bcd(13), to_bcd(34)); else pass++;
      total++; if (cq[1] - cq[0] != 17) $display("FAIL b2b_spacing got %0d want 17", cq[1] - cq[0]); else pass++;
    end
  endtask
  task automatic test_blank;
    logic [3:0][6:0] s; logic [3:0] seen; int bad;
    strobe(7);
    repeat (26) @(negedge clk);
    observe_scan(24, s, seen, bad);
    total++; if ({bcd, over} !== {to_bcd(7), 1'b0}) $display("FAIL blank_result got %h/%b want %h/0", bcd, over, to_bcd(7)); else pass++;
    total++; if (seen !== 4'hf || bad != 0) $display("FAIL blank_scan seen=%b bad=%0d want 1111/0", seen, bad); else pass++;
    total++; if (s !== {7'h7f, 7'h7f, 7'h7f, 7'b1111000}) $display("FAIL blank_segs got %h", s); else pass++;
  endtask
  task automatic test_random;
    logic [3:0][6:0] s; logic [3:0][6:0] e; logic [3:0] seen; int bad, k, v;
    for (int n = 0; n < 8; n++) begin
      v = (n < 4) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      strobe(v);
      k = 0;
      while (!bcd_valid && k < 40) begin @(negedge clk); k++; end
      total++; if (!bcd_valid) $display("FAIL rand_timeout v=%0d no bcd_valid", v); else pass++;
      total++; if ({bcd, over} !== {to_bcd(v), 1'(v > 9999)})
        $display("FAIL rand_result v=%0d got %h/%b want %h/%b", v, bcd, over, to_bcd(v), v > 9999); else pass++;
      repeat (8) @(negedge clk);
      observe_scan(20, s, seen, bad);
      for (int i = 0; i < 4; i++) e[i] = exp_seg(v, i);
      total++; if (s !== e || bad != 0) $display("FAIL rand_segs v=%0d got %h want %h bad=%0d", v, s, e, bad); else pass++;
    end
  endtask
  task automatic test_reset_mid;
    int k;
    vq.delete();
    strobe(610);
    repeat (7) @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++; if ({bcd_valid, bcd, busy, an, seg} !== {1'b0, 20'h0, 1'b0, 4'hf, 7'h7f})
      $display("FAIL mid_reset got v=%b bcd=%h b=%b an=%b seg=%b", bcd_valid, bcd, busy, an, seg); else pass++;
    @(negedge clk);
    rst = 1;
    repeat (25) @(negedge clk);
    total++; if (vq.size() != 0 || busy !== 0) $display("FAIL mid_discard pulses=%0d busy=%b want 0/0", vq.size(), busy); else pass++;
    strobe(89);
    repeat (15) @(negedge clk);
    k = 0;
    while (!bcd_valid && k < 5) begin @(negedge clk); k++; end
    total++; if ({bcd_valid, bcd} !== {1'b1, to_bcd(89)} || k != 1)
      $display("FAIL mid_recover got v=%b bcd=%h lat+%0d want 1/%h/+1", bcd_valid, bcd, k, to_bcd(89)); else pass++;
  endtask
  initial begin
    test_reset;
    test_single;
    test_max;
    test_back_to_back;
    test_blank;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/fib_bcd_display.md
Name: fib_bcd_display

Overview:
- Downstream consumer of the 16-bit Fibonacci generator output.
- Captures a binary value on a valid strobe and converts it to 5-digit BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Time-multiplexes the low 4 BCD digits onto a 4-digit common-anode 7-segment display and flags values above 9999.

Parameters:
- WIDTH, 16, binary input width. The BCD datapath is sized for 16 bits only.
- SCAN_DIV, 100000, clocks per digit slot. At 100 MHz this gives a 1 kHz digit rate. Minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_val  in  16  binary value from the Fibonacci stage
- in_valid  in  1  one-cycle strobe; in_val is valid this cycle
- busy  out  1  high while a conversion is in progress or pending
- bcd  out  20  last completed result, {ten-thousands, thousands, hundreds, tens, ones}
- bcd_valid  out  1  one-cycle pulse when bcd updates
- over  out  1  high when the last completed result is > 9999
- an  out  4  digit anodes, active-low; an[0] = ones (rightmost)
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst=0, asynchronous) state and outputs:
  - state=IDLE; pending cleared
  - bcd=0, bcd_valid=0, over=0, busy=0
  - an=4'b1111, seg=7'b1111111
  - scan divider and digit index = 0
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_valid=1 at edge T: load in_val into the shift register, clear the BCD scratch, set bit count to 0, go to SHIFT.
- SHIFT:
  - Each edge: add 3 to every scratch nibble >= 5, then shift {scratch, shift register} left by 1.
  - Bit count 15 completes at edge T+16: bcd is written, over = (ten-thousands nibble != 0), bcd_valid=1, go to DONE.
  - Latency from capture edge to result: exactly 16 clocks.
- DONE (one cycle, bcd_valid=1):
  - pending valid at the next edge: start SHIFT with the pending value and clear pending.
  - else, in_valid=1: start SHIFT with in_val directly.
  - else: go to IDLE.
- Pending buffer (1 deep):
  - in_valid during SHIFT writes in_val into pending and sets pending valid.
  - A later strobe overwrites it; only the newest request survives.
  - in_valid in DONE while pending is valid: pending is consumed into the engine and the new in_val replaces it in pending on the same edge.
- busy = (state != IDLE) | pending valid.
- Width rule: the scratch register is 20 bits. The maximum input 65535 gives 0x65535, so no overflow is possible.
- Display scan:
  - A free-running divider counts 0..SCAN_DIV-1. On wrap, the digit index increments mod 4.
  - an and seg are registered and update on that same wrap edge; an is one-hot low on the selected digit.
  - Digit source is bcd[4i+3:4i].
- Leading-zero blanking:
  - Digits 3..1 show blank (seg=7'b1111111) when they and every higher displayed digit are 0.
  - Digit 0 always shows.
- Overflow display: when over=1 the display shows the low 4 digits unblanked, and the over output drives the board LED.
- Display source: it shows only completed results; it never shows intermediate scratch.
- Reset mid-conversion: the result is discarded, pending is cleared, and all outputs return to reset values.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - 7-segment constants SEG_0..SEG_9 and SEG_BLANK, e.g. SEG_0=7'b1000000, SEG_5=7'b0010010, SEG_7=7'b1111000
- One combinational sub-module: seg7_decode (4-bit digit + blank in, 7-bit seg out).
- The double-dabble FSM and the scanner stay in the top level.

Test Plan:
- Reset then idle: hold rst=0 for 3 clocks, release, run with SCAN_DIV=4 for 20 clocks -> bcd=0, over=0, busy=0; only an=4'b1110 ever shows seg=SEG_0; the other digits show seg=7'b1111111.
- Single conversion: in_val=1234, in_valid pulse at edge T -> busy=1 from T; bcd_valid high exactly in cycle T+16..T+17; bcd=20'h01234, over=0; busy=0 after T+17.
- Max value: in_val=65535 -> bcd=20'h65535, over=1; scan shows 5,5,3,5 on an[3..0] with no blanking.
- Back-to-back: strobes with 13 at T, 21 at T+3, 34 at T+8 -> exactly two bcd_valid pulses, results 0x00013 then 0x00034; 21 is never reported. The second conversion starts at edge T+17.
- Blanking/scan: in_val=7, SCAN_DIV=4 -> an cycles 1110,1101,1011,0111 every 4 clocks; seg=7'b1111000 on an=1110 and blank on the others.
- Reset mid-operation: strobe 610, assert rst at T+8 for 2 clocks -> no bcd_valid pulse, bcd=0, busy=0; a new strobe of 89 after release yields bcd=20'h00089 16 clocks later.
